// File: rtl/gpio_step_sequencer.sv
// Avalon-MM step/dir pulse sequencer: a command FIFO feeds a SETUP/PULSE/GAP timing FSM.
// Define GPIO_STEP_IRQ_EN to build the drain interrupt; otherwise irq is tied low.
module gpio_step_sequencer #(
  parameter int unsigned NUM_AXES   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_AXES-1:0] step_out,
  output logic [NUM_AXES-1:0] dir_out,
  output logic                busy,
  output logic                irq
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = 16 + 2 * NUM_AXES;

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StGap} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_AXES-1:0]   mask_q, mask_d;
  logic [15:0]           interval_q, interval_d;
  logic [NUM_AXES-1:0]   step_out_q, step_out_d;
  logic [NUM_AXES-1:0]   dir_out_q, dir_out_d;
  logic [31:0]           timing_q, timing_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         level_q, level_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [EntW-1:0]       fifo_mem_q [FIFO_DEPTH];

  logic wr_en, flush, push, push_ok, pop, full, empty;
  logic [EntW-1:0]     head;
  logic [15:0]         setup_len, pulse_len;
  logic                unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign flush     = wr_en && (address == 2'd3) && writedata[1];
  assign push      = wr_en && (address == 2'd0) && !flush;
  assign full      = (level_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  // A pop frees a slot in the same cycle, so a push while full is still accepted.
  assign push_ok   = push && (!full || pop);
  assign head      = fifo_mem_q[rd_ptr_q];
  assign setup_len = (timing_q[31:16] == '0) ? 16'd1 : timing_q[31:16];
  assign pulse_len = (timing_q[15:0] == '0) ? 16'd1 : timing_q[15:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    timing_d   = timing_q;
    enable_d   = enable_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      level_d = level_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
    end
    if (wr_en && (address == 2'd2) && writedata[2]) overflow_d = 1'b0;
    if (push && !push_ok) overflow_d = 1'b1;
    if (wr_en && (address == 2'd1)) timing_d = writedata;
    if (wr_en && (address == 2'd3)) enable_d = writedata[0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    interval_d = interval_q;
    step_out_d = step_out_q;
    dir_out_d  = dir_out_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_q && !empty && !flush) begin
          pop        = 1'b1;
          mask_d     = head[NUM_AXES-1:0];
          interval_d = head[EntW-1 -: 16];
          if (head[2*NUM_AXES-1:NUM_AXES] != dir_out_q) begin
            dir_out_d = head[2*NUM_AXES-1:NUM_AXES];
            state_d   = StSetup;
            cnt_d     = CNT_W'(setup_len);
          end else begin
            state_d    = StPulse;
            cnt_d      = CNT_W'(pulse_len);
            step_out_d = head[NUM_AXES-1:0];
          end
        end
      end
      StSetup: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = StPulse;
          cnt_d      = CNT_W'(pulse_len);
          step_out_d = mask_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StPulse: begin
        if (cnt_q == CNT_W'(1)) begin
          step_out_d = '0;
          if (interval_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = CNT_W'(interval_q);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == CNT_W'(1)) state_d = StIdle;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
    // Flush aborts the command in flight but leaves dir_out where it was.
    if (flush) begin
      state_d    = StIdle;
      step_out_d = '0;
    end
  end

`ifdef GPIO_STEP_IRQ_EN
  logic irq_q, irq_d, irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    irq_d    = irq_q;
    if (wr_en && (address == 2'd3)) irq_en_d = writedata[2];
    if (irq_en_q && (state_q != StIdle) && (state_d == StIdle) && (level_d == '0)) irq_d = 1'b1;
    if (wr_en && (address == 2'd2) && writedata[3]) irq_d = 1'b0;
    if (!irq_en_q) irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d = '0;
      2'd1: readdata_d = timing_q;
      2'd2: begin
        readdata_d[23:16] = 8'(level_q);
        readdata_d[2]     = overflow_q;
        readdata_d[1]     = full;
        readdata_d[0]     = empty;
`ifdef GPIO_STEP_IRQ_EN
        readdata_d[3]     = irq_q;
`endif
      end
      2'd3: begin
        readdata_d[0] = enable_q;
`ifdef GPIO_STEP_IRQ_EN
        readdata_d[2] = irq_en_q;
`endif
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {writedata[31:16], writedata[8 +: NUM_AXES], writedata[0 +: NUM_AXES]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mask_q     <= '0;
      interval_q <= '0;
      step_out_q <= '0;
      dir_out_q  <= '0;
      timing_q   <= 32'h0001_0001;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      interval_q <= interval_d;
      step_out_q <= step_out_d;
      dir_out_q  <= dir_out_d;
      timing_q   <= timing_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign step_out = step_out_q;
  assign dir_out  = dir_out_q;
  assign busy     = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_gpio_step_sequencer.sv
// Scoreboard bench for gpio_step_sequencer: expected reads and per-cycle output words are
// queued as stimulus is driven and compared as the DUT produces them.
module tb_gpio_step_sequencer;
`ifdef GPIO_STEP_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  step_out, dir_out;
  logic        busy, irq;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  gpio_step_sequencer #(
    .NUM_AXES  (4),
    .FIFO_DEPTH(8),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] pk(input logic i, input logic b, input logic [3:0] d,
                                     input logic [3:0] s);
    return {22'd0, i, b, d, s};
  endfunction

  function automatic logic [31:0] obs();
    return {22'd0, irq, busy, dir_out, step_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    check(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  task automatic expect_out(input string tag, input int n, input logic [31:0] exp);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
  endtask

  task automatic play();
    while (exp_q.size() > 0) begin
      tick();
      check(tag_q.pop_front(), obs(), exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_outputs", obs(), pk(0, 0, 4'h0, 4'h0));
    rd(2'd0, 32'h0000_0000, "rst_cmd");
    rd(2'd1, 32'h0001_0001, "rst_timing");
    rd(2'd2, 32'h0000_0001, "rst_status");
    rd(2'd3, 32'h0000_0000, "rst_ctrl");

    // dir change: 3 SETUP, 2 PULSE of 0x5, 4 GAP, then idle
    wr(2'd1, 32'h0003_0002);
    wr(2'd3, 32'h0000_0001);
    wr(2'd0, 32'h0004_0105);
    check("t2_pushed", obs(), pk(0, 1, 4'h0, 4'h0));
    expect_out("t2_setup", 3, pk(0, 1, 4'h1, 4'h0));
    expect_out("t2_pulse", 2, pk(0, 1, 4'h1, 4'h5));
    expect_out("t2_gap",   4, pk(0, 1, 4'h1, 4'h0));
    expect_out("t2_done",  1, pk(0, 0, 4'h1, 4'h0));
    play();

    // Overflow with enable off
    wr(2'd3, 32'h0000_0000);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h0000_0300 | 32'(i));
    rd(2'd2, 32'h0008_0006, "t3_full_ovf");
    wr(2'd2, 32'h0000_0004);
    rd(2'd2, 32'h0008_0002, "t3_ovf_clr");
    wr(2'd3, 32'h0000_0002);
    rd(2'd2, 32'h0000_0001, "t3_flushed");
    rd(2'd3, 32'h0000_0000, "t3_ctrl");

    // Same dir, interval 0, pulse_w 1: 1,0,1 with no SETUP
    wr(2'd1, 32'h0005_0001);
    wr(2'd0, 32'h0000_0101);
    wr(2'd0, 32'h0000_0101);
    wr(2'd3, 32'h0000_0001);
    check("t4_enabled", obs(), pk(0, 1, 4'h1, 4'h0));
    expect_out("t4_p1",   1, pk(0, 1, 4'h1, 4'h1));
    expect_out("t4_low",  1, pk(0, 1, 4'h1, 4'h0));
    expect_out("t4_p2",   1, pk(0, 1, 4'h1, 4'h1));
    expect_out("t4_idle", 1, pk(0, 0, 4'h1, 4'h0));
    play();

    // Flush mid-pulse of a 10-cycle pulse; a second queued command is discarded
    wr(2'd1, 32'h0001_000A);
    wr(2'd0, 32'h0000_020A);
    wr(2'd0, 32'h0000_020A);
    check("t5_setup", obs(), pk(0, 1, 4'h2, 4'h0));
    expect_out("t5_pulse", 2, pk(0, 1, 4'h2, 4'hA));
    play();
    wr(2'd3, 32'h0000_0003);
    check("t5_flush", obs(), pk(0, 0, 4'h2, 4'h0));
    expect_out("t5_hold", 1, pk(0, 0, 4'h2, 4'h0));
    play();
    rd(2'd2, 32'h0000_0001, "t5_status");

    // Drain interrupt (absent in the default build)
    wr(2'd1, 32'h0001_0001);
    wr(2'd3, 32'h0000_0005);
    rd(2'd3, IrqOn ? 32'h0000_0005 : 32'h0000_0001, "t6_ctrl");
    wr(2'd0, 32'h0002_0201);
    check("t6_pushed", obs(), pk(0, 1, 4'h2, 4'h0));
    expect_out("t6_pulse", 1, pk(0, 1, 4'h2, 4'h1));
    expect_out("t6_gap",   2, pk(0, 1, 4'h2, 4'h0));
    expect_out("t6_irq",   1, pk(IrqOn, 0, 4'h2, 4'h0));
    play();
    rd(2'd2, IrqOn ? 32'h0000_0009 : 32'h0000_0001, "t6_status_irq");
    wr(2'd2, 32'h0000_0008);
    check("t6_irq_clr", obs(), pk(0, 0, 4'h2, 4'h0));
    rd(2'd2, 32'h0000_0001, "t6_status_clr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_step_sequencer.md
Name: gpio_step_sequencer

Overview:
- Avalon-MM slave that schedules timed step/dir pulse patterns onto FPGA GPIO lines for the printer's stepper drivers.
- HPS software pushes step commands into a small command FIFO. A state machine then plays them out with a programmable dir-setup time, pulse width and inter-step interval.
- This offloads pulse timing from the HPS and replaces bit-banging through the plain PIO port.

Parameters:
- NUM_AXES, 4, number of step/dir output pairs (1..8).
- FIFO_DEPTH, 8, command FIFO entries (power of two, 2..64).
- CNT_W, 16, width of the timing counters and timing fields.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- step_out  out  NUM_AXES  step pulses, active high.
- dir_out  out  NUM_AXES  direction levels.
- busy  out  1  sequencer not IDLE, or FIFO not empty.
- irq  out  1  drain interrupt (optional feature only).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on `reset`.
- Write qualifier: a write occurs when chipselect=1 and write_n=0.
- readdata is registered with 1-cycle latency. It updates every cycle from address, regardless of chipselect.
- Register map:
  - addr0 CMD (write): push {interval[31:16], dir[15:8], step[7:0]}. Only the low NUM_AXES bits of dir and step are used. Reads return 0.
  - addr1 TIMING (read/write): pulse_w[15:0], dir_setup[31:16]. Reset value 0x0001_0001.
  - addr2 STATUS: read returns {level[23:16], overflow[2], full[1], empty[0]}. Writing 1 to bit2 clears overflow.
  - addr3 CTRL (read/write): enable[0], irq_en[2]. Writing 1 to bit1 is a flush pulse; bit1 always reads 0.
- FIFO behaviour:
  - Push when full: the command is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: the push is accepted and level is unchanged.
  - Flush: empties the FIFO and forces the FSM to IDLE with step_out=0. dir_out holds its value. Flush takes priority over a same-cycle push, so that push is discarded without setting overflow.
- FSM states: IDLE, SETUP, PULSE, GAP.
  - IDLE: if enable=1 and the FIFO is non-empty, pop and latch the command. If the command's dir differs from dir_out: update dir_out and go to SETUP. Otherwise go to PULSE.
  - SETUP: lasts max(dir_setup,1) cycles, then goes to PULSE.
  - PULSE: step_out equals the step mask for max(pulse_w,1) cycles, then goes to GAP.
  - GAP: step_out=0 for interval cycles. interval=0 means GAP is skipped and the FSM goes straight to IDLE. Otherwise GAP returns to IDLE.
  - IDLE itself costs 1 cycle, so back-to-back commands with interval 0 have a 1-cycle low gap between pulses.
- A step mask of all zeros still executes the timing as a pure delay.
- Clearing enable mid-command lets the current command finish; no new pop occurs.
- TIMING writes take effect at the next counter load. The current phase's count is unaffected.
- Reset values: step_out=0, dir_out=0, readdata=0, FIFO empty, overflow=0, CTRL=0, state IDLE, irq=0, busy=0.
- busy is combinational from state and empty.
- Counters are CNT_W bits; no wrap is possible because each count is loaded and then decremented to 1.

Optional Feature:
- Macro: GPIO_STEP_IRQ_EN.
- Defined: irq is a registered output. It is set on the cycle the FSM enters IDLE with the FIFO empty, while irq_en=1. It stays set until a write to STATUS with bit3=1, or until irq_en=0. STATUS bit3 reads the irq state.
- Undefined: irq is tied to 0, irq_en reads 0, STATUS bit3 reads 0, and no interrupt logic is built.

Test Plan:
1. Reset, then read addrs 0..3 → 0, 0x00010001, 0x00000001, 0; outputs all 0.
2. TIMING=0x0003_0002, enable=1, push CMD 0x0004_0105 → dir_out=0x1; after 3 cycles of SETUP, step_out=0x5 for 2 cycles, then 4 cycles low, then busy=0.
3. Push 9 commands with enable=0 (FIFO_DEPTH=8) → STATUS level=8, full=1, overflow=1; write STATUS 0x4 → overflow=0.
4. Two CMDs with the same dir and interval 0, pulse_w=1 → step_out pattern 1,0,1 with no SETUP phase.
5. Flush during PULSE of a 10-cycle pulse → step_out=0 the next cycle, empty=1, dir_out unchanged.
6. (GPIO_STEP_IRQ_EN) irq_en=1, one command drains → irq=1 after GAP; STATUS write 0x8 → irq=0.
